// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline: load-size encodings, the zero
// register id, the MEM/WB register layout and a sub-word extension helper.
package mips_pkg;

    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10,
        LS_RSVD = 2'b11   // reserved encoding, treated as a word load
    } load_size_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        load_size_e  load_size;
        logic        load_signed;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
    } mwb_t;

    // Widen a 16-bit field to 32 bits. For byte loads only raw[7:0] is
    // meaningful, so is_half selects which bit carries the sign.
    function automatic logic [31:0] extend_sub(input logic [15:0] raw,
                                               input logic        is_half,
                                               input logic        sgn);
        logic [31:0] res;
        if (is_half) begin
            res = {{16{sgn & raw[15]}}, raw};
        end else begin
            res = {{24{sgn & raw[7]}}, raw[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian load extraction: picks the byte/half addressed by addr_i out of
// the raw memory word, zero- or sign-extends it, and flags addresses that are
// not naturally aligned for the access size. Purely combinational.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_i,
    input  load_size_e  size_i,
    input  logic        signed_i,
    output logic [31:0] value_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] value_s;
    logic        misalign_s;

    // Select the addressed byte and half-word (address 0 is the MSB end)
    always_comb begin
        byte_s = 8'h00;
        case (addr_i)
            2'b00:   byte_s = data_i[31:24];
            2'b01:   byte_s = data_i[23:16];
            2'b10:   byte_s = data_i[15:8];
            2'b11:   byte_s = data_i[7:0];
            default: byte_s = 8'h00;
        endcase
        if (addr_i[1]) begin
            half_s = data_i[15:0];
        end else begin
            half_s = data_i[31:16];
        end
    end

    // Size-dependent extension and alignment check
    always_comb begin
        value_s    = data_i;
        misalign_s = 1'b0;
        case (size_i)
            LS_HALF: begin
                value_s    = extend_sub(half_s, 1'b1, signed_i);
                misalign_s = addr_i[0];
            end
            LS_BYTE: begin
                value_s    = extend_sub({8'h00, byte_s}, 1'b0, signed_i);
                misalign_s = 1'b0;
            end
            LS_WORD, LS_RSVD: begin
                value_s    = data_i;
                misalign_s = (addr_i != 2'b00);
            end
            default: begin
                value_s    = data_i;
                misalign_s = 1'b0;
            end
        endcase
    end

    assign value_o    = value_s;
    assign misalign_o = misalign_s;

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB pipeline register, load alignment and the
// qualified register-file write enable.
// Optional retire counter: define WRITEBACK_RETIRE_COUNT_EN to add a 32-bit
// wrapping count of captured valid instructions on port RetireCountW.
// Register update priority: reset > StallW > FlushW > capture.
module writeback_stage
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        StallW,
    input  logic        FlushW,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [1:0]  LoadSizeM,
    input  logic        LoadSignedM,
    input  logic [31:0] ReadDataM,
    input  logic [31:0] ALUOutM,
    input  logic [4:0]  WriteRegM,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW,
    output logic        MisalignW
`ifdef WRITEBACK_RETIRE_COUNT_EN
    ,
    output logic [31:0] RetireCountW
`endif
);

    localparam mwb_t MWB_RESET = '{
        valid:       1'b0,
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        load_size:   LS_WORD,
        load_signed: 1'b0,
        read_data:   32'h0000_0000,
        alu_out:     32'h0000_0000,
        write_reg:   5'd0
    };

    mwb_t        mwb_q;
    mwb_t        mwb_d;
    logic        capture_s;
    logic [31:0] aligned_s;
    logic        align_mis_s;

    assign capture_s = ~StallW & ~FlushW;

    // Next-state of the MEM/WB register: stall holds (even with flush),
    // flush kills valid and write enable, otherwise capture the M stage
    always_comb begin
        mwb_d = mwb_q;
        if (StallW) begin
            mwb_d = mwb_q;
        end else if (FlushW) begin
            mwb_d.valid     = 1'b0;
            mwb_d.reg_write = 1'b0;
        end else begin
            mwb_d.valid       = ValidM;
            mwb_d.reg_write   = RegWriteM;
            mwb_d.mem_to_reg  = MemtoRegM;
            mwb_d.load_size   = load_size_e'(LoadSizeM);
            mwb_d.load_signed = LoadSignedM;
            mwb_d.read_data   = ReadDataM;
            mwb_d.alu_out     = ALUOutM;
            mwb_d.write_reg   = WriteRegM;
        end
    end

    // MEM/WB register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            mwb_q <= MWB_RESET;
        end else begin
            mwb_q <= mwb_d;
        end
    end

`ifdef WRITEBACK_RETIRE_COUNT_EN
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    // Count one retirement per captured valid instruction; wraps naturally
    always_comb begin
        if (capture_s & ValidM) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign RetireCountW = retire_cnt_q;
`endif

    load_align u_load_align (
        .data_i     (mwb_q.read_data),
        .addr_i     (mwb_q.alu_out[1:0]),
        .size_i     (mwb_q.load_size),
        .signed_i   (mwb_q.load_signed),
        .value_o    (aligned_s),
        .misalign_o (align_mis_s)
    );

    // Result mux and write qualification, all from registered state
    always_comb begin
        if (mwb_q.mem_to_reg) begin
            ResultW = aligned_s;
        end else begin
            ResultW = mwb_q.alu_out;
        end
        MisalignW = mwb_q.valid & mwb_q.mem_to_reg & align_mis_s;
        RegWriteW = mwb_q.valid & mwb_q.reg_write &
                    (mwb_q.write_reg != REG_ZERO) & ~MisalignW;
    end

    assign ValidW    = mwb_q.valid;
    assign WriteRegW = mwb_q.write_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// random traffic, all compared against a behavioural model of the stage.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset, StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
    logic [1:0]  LoadSizeM;
    logic        LoadSignedM;
    logic [31:0] ReadDataM, ALUOutM;
    logic [4:0]  WriteRegM;
    logic        ValidW, RegWriteW, MisalignW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
`ifdef WRITEBACK_RETIRE_COUNT_EN
    logic [31:0] RetireCountW;
`endif

    writeback_stage dut (
        .clock       (clock),
        .reset       (reset),
        .StallW      (StallW),
        .FlushW      (FlushW),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .LoadSizeM   (LoadSizeM),
        .LoadSignedM (LoadSignedM),
        .ReadDataM   (ReadDataM),
        .ALUOutM     (ALUOutM),
        .WriteRegM   (WriteRegM),
        .ValidW      (ValidW),
        .RegWriteW   (RegWriteW),
        .WriteRegW   (WriteRegW),
        .ResultW     (ResultW),
        .MisalignW   (MisalignW)
`ifdef WRITEBACK_RETIRE_COUNT_EN
        ,
        .RetireCountW(RetireCountW)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model of what the W stage currently holds
    logic        m_v, m_rw, m_mtr, m_lsg, m_known;
    logic [1:0]  m_ls;
    logic [31:0] m_rd, m_alu, m_cnt;
    logic [4:0]  m_wr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs present at the edge
    task automatic model_edge();
        if (reset) begin
            m_v = 1'b0; m_rw = 1'b0; m_mtr = 1'b0; m_lsg = 1'b0; m_ls = 2'b00;
            m_rd = 32'h0; m_alu = 32'h0; m_wr = 5'd0; m_cnt = 32'h0; m_known = 1'b1;
        end else if (StallW) begin
            m_known = m_known;
        end else if (FlushW) begin
            m_v = 1'b0; m_rw = 1'b0; m_known = 1'b0;
        end else begin
            m_v = ValidM; m_rw = RegWriteM; m_mtr = MemtoRegM; m_ls = LoadSizeM;
            m_lsg = LoadSignedM; m_rd = ReadDataM; m_alu = ALUOutM; m_wr = WriteRegM;
            m_known = 1'b1;
            if (ValidM) m_cnt = m_cnt + 32'd1;
        end
    endtask

    function automatic logic [31:0] exp_result();
        int          addr;
        logic [31:0] v;
        addr = int'(m_alu[1:0]);
        if (!m_mtr) return m_alu;
        if (m_ls == 2'b10) begin
            v = (m_rd >> (8 * (3 - addr))) & 32'h0000_00FF;
            if (m_lsg && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (m_ls == 2'b01) begin
            v = (m_rd >> (16 * (1 - addr / 2))) & 32'h0000_FFFF;
            if (m_lsg && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        return m_rd;
    endfunction

    function automatic logic exp_misalign();
        int addr;
        addr = int'(m_alu[1:0]);
        if (!(m_v && m_mtr)) return 1'b0;
        if (m_ls == 2'b01) return (addr % 2) != 0;
        if (m_ls == 2'b10) return 1'b0;
        return addr != 0;
    endfunction

    task automatic check_outputs();
        logic mis;
        mis = exp_misalign();
        check_val("valid", {31'd0, ValidW}, {31'd0, m_v});
        check_val("misalign", {31'd0, MisalignW}, {31'd0, mis});
        check_val("regwrite", {31'd0, RegWriteW}, {31'd0, m_v && m_rw && (m_wr != 5'd0) && !mis});
        if (m_known) begin
            check_val("writereg", {27'd0, WriteRegW}, {27'd0, m_wr});
            check_val("result", ResultW, exp_result());
        end
`ifdef WRITEBACK_RETIRE_COUNT_EN
        check_val("retire_cnt", RetireCountW, m_cnt);
`endif
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_in(input logic v, input logic rw, input logic mtr, input logic [1:0] ls,
                          input logic lsg, input logic [31:0] rd, input logic [31:0] alu,
                          input logic [4:0] wr);
        reset = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        ValidM = v; RegWriteM = rw; MemtoRegM = mtr; LoadSizeM = ls;
        LoadSignedM = lsg; ReadDataM = rd; ALUOutM = alu; WriteRegM = wr;
    endtask

    initial begin
        set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h5555_5555, 5'd3);
        reset = 1'b1;
        cycle();
        check_val("rst_result", ResultW, 32'h0);
        check_val("rst_valid", {31'd0, ValidW}, 32'd0);

        // ALU result write-back
        set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, $urandom, 32'h0000_1234, 5'd8);
        cycle();
        check_val("alu_result", ResultW, 32'h0000_1234);
        check_val("alu_regwrite", {31'd0, RegWriteW}, 32'd1);
        check_val("alu_writereg", {27'd0, WriteRegW}, 32'd8);

        // Byte loads at address 1, signed then unsigned
        set_in(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h11AA_2233, 32'h0000_1001, 5'd5);
        cycle();
        check_val("lb_signed", ResultW, 32'hFFFF_FFAA);
        set_in(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h11AA_2233, 32'h0000_1001, 5'd5);
        cycle();
        check_val("lb_unsigned", ResultW, 32'h0000_00AA);

        // Misaligned half load, then a write to register zero
        set_in(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h1234_5678, 32'h0000_0101, 5'd3);
        cycle();
        check_val("lh_misalign", {31'd0, MisalignW}, 32'd1);
        check_val("lh_mis_regwrite", {31'd0, RegWriteW}, 32'd0);
        set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0077, 5'd0);
        cycle();
        check_val("r0_regwrite", {31'd0, RegWriteW}, 32'd0);

        // Stall holds for three cycles while inputs change
        set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_CAFE, 5'd9);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, $urandom, $urandom, 5'd12);
            StallW = 1'b1;
            cycle();
            check_val("stall_hold", ResultW, 32'h0000_CAFE);
        end
        StallW = 1'b1; FlushW = 1'b1;
        cycle();
        check_val("stallflush_valid", {31'd0, ValidW}, 32'd1);
        check_val("stallflush_result", ResultW, 32'h0000_CAFE);
        StallW = 1'b0; FlushW = 1'b1;
        cycle();
        check_val("flush_valid", {31'd0, ValidW}, 32'd0);
        check_val("flush_regwrite", {31'd0, RegWriteW}, 32'd0);

`ifdef WRITEBACK_RETIRE_COUNT_EN
        reset = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, $urandom, 5'd4);
            cycle();
        end
        FlushW = 1'b1;
        cycle();
        FlushW = 1'b0; StallW = 1'b1;
        cycle();
        cycle();
        check_val("retire_five", RetireCountW, 32'd5);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h10, 5'd4);
        cycle();
        check_val("retire_wrap", RetireCountW, 32'd0);
`endif

        // Reset in the middle of valid traffic
        set_in(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'h3, 5'd7);
        cycle();
        reset = 1'b1; StallW = 1'b1; FlushW = 1'b1;
        cycle();
        check_val("midrst_result", ResultW, 32'h0);
        check_val("midrst_writereg", {27'd0, WriteRegW}, 32'd0);
        check_val("midrst_regwrite", {31'd0, RegWriteW}, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, $urandom, 5'($urandom));
            reset  = ($urandom_range(0, 39) == 0);
            StallW = ($urandom_range(0, 5) == 0);
            FlushW = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
